// File: rtl/rf80386_prefetch_queue.sv
// rf80386_prefetch_queue
// Circular byte prefetch queue between the instruction-cache bundle port and
// the decoder. It fetches line-aligned bundles ahead of decode, lets the
// decoder consume 0..PEEK bytes per cycle and exposes a PEEK-byte opcode
// window padded with NOPs (8'h90).
// Optional build macro: RF80386_PFQ_PERF_EN adds hit_cnt_o / starve_cnt_o.

module rf80386_prefetch_queue #(
  parameter int unsigned LINE_BYTES = 16,
  parameter int unsigned QBYTES     = 32,
  parameter int unsigned PEEK       = 8,
  parameter logic [31:0] RESET_ADR  = 32'hFFF00000
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic [31:0]                   flush_adr_i,
  output logic                          fetch_req_o,
  output logic [31:0]                   fetch_adr_o,
  input  logic [LINE_BYTES*8-1:0]       ibundle_i,
  input  logic                          ihit_i,
  output logic [PEEK*8-1:0]             peek_o,
  output logic [$clog2(QBYTES):0]       count_o,
  input  logic [$clog2(PEEK):0]         take_i,
  output logic [31:0]                   eip_o
`ifdef RF80386_PFQ_PERF_EN
  ,
  output logic [31:0]                   hit_cnt_o,
  output logic [31:0]                   starve_cnt_o
`endif
);

  localparam int unsigned QW  = $clog2(QBYTES);
  localparam int unsigned CW  = QW + 1;
  localparam int unsigned LBW = $clog2(LINE_BYTES);

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  logic [7:0]     queue [QBYTES];
  logic [QW-1:0]  rp;
  logic [QW-1:0]  wp;
  logic [CW-1:0]  count;
  logic [31:0]    eip;
  logic [31:0]    fetch_adr;
  logic           first_line;
  logic           fetch_req;
  state_t         state;

  logic           wr_en;
  logic [LBW-1:0] skip;
  logic [CW-1:0]  wr_len;
  logic [CW-1:0]  take_ext;
  logic [CW-1:0]  take_eff;
  logic [CW-1:0]  count_next;
  logic [CW-1:0]  free_next;

  // Write qualification, first-line skip, effective take and next occupancy.
  always_comb begin
    wr_en    = ihit_i & fetch_req & ~flush_i & ~rst_i;
    // Nothing is consumed before the first write after a flush, so the low
    // bits of eip still hold the restart offset inside the first line.
    if (first_line) begin
      skip = eip[LBW-1:0];
    end else begin
      skip = '0;
    end
    wr_len   = CW'(LINE_BYTES) - CW'(skip);
    take_ext = CW'(take_i);
    if (take_ext < count) begin
      take_eff = take_ext;
    end else begin
      take_eff = count;
    end
    if (wr_en) begin
      count_next = count + wr_len - take_eff;
    end else begin
      count_next = count - take_eff;
    end
    free_next = CW'(QBYTES) - count_next;
  end

  // Pointers, occupancy, addresses and the fetch request state machine.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rp         <= '0;
      wp         <= '0;
      count      <= '0;
      eip        <= rst_i ? RESET_ADR : flush_adr_i;
      fetch_adr  <= (rst_i ? RESET_ADR : flush_adr_i) & ~(32'(LINE_BYTES) - 32'd1);
      first_line <= 1'b1;
      fetch_req  <= 1'b0;
      state      <= ST_FILL;
    end else begin
      count <= count_next;
      rp    <= rp + QW'(take_eff);
      eip   <= eip + 32'(take_eff);
      if (wr_en) begin
        wp         <= wp + QW'(wr_len);
        fetch_adr  <= fetch_adr + 32'(LINE_BYTES);
        first_line <= 1'b0;
      end
      case (state)
        ST_FILL: begin
          if (free_next < CW'(LINE_BYTES)) begin
            state     <= ST_WAIT;
            fetch_req <= 1'b0;
          end else begin
            state     <= ST_FILL;
            fetch_req <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (free_next >= CW'(LINE_BYTES)) begin
            state     <= ST_FILL;
            fetch_req <= 1'b1;
          end else begin
            state     <= ST_WAIT;
            fetch_req <= 1'b0;
          end
        end
        default: begin
          state     <= ST_FILL;
          fetch_req <= 1'b0;
        end
      endcase
    end
  end

  // Byte storage: copy bundle bytes skip..LINE_BYTES-1 into the ring at wp.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int i = 0; i < LINE_BYTES; i++) begin
        if (LBW'(i) >= skip) begin
          queue[wp + QW'(i) - QW'(skip)] <= ibundle_i[i*8 +: 8];
        end
      end
    end
  end

  // Decoder window: valid bytes from rp onward, NOP padding past count.
  always_comb begin
    peek_o = '0;
    for (int k = 0; k < PEEK; k++) begin
      if (CW'(k) < count) begin
        peek_o[k*8 +: 8] = queue[rp + QW'(k)];
      end else begin
        peek_o[k*8 +: 8] = 8'h90;
      end
    end
  end

  assign fetch_req_o = fetch_req;
  assign fetch_adr_o = fetch_adr;
  assign count_o     = count;
  assign eip_o       = eip;

`ifdef RF80386_PFQ_PERF_EN
  logic [31:0] hit_cnt;
  logic [31:0] starve_cnt;

  // Saturating performance counters, cleared only by reset (not by flush).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt    <= 32'd0;
      starve_cnt <= 32'd0;
    end else begin
      if (wr_en && (hit_cnt != 32'hFFFFFFFF)) begin
        hit_cnt <= hit_cnt + 32'd1;
      end
      if ((count < take_ext) && (starve_cnt != 32'hFFFFFFFF)) begin
        starve_cnt <= starve_cnt + 32'd1;
      end
    end
  end

  assign hit_cnt_o    = hit_cnt;
  assign starve_cnt_o = starve_cnt;
`endif

endmodule

// File: tb/tb_rf80386_prefetch_queue.sv
// Self-checking bench for rf80386_prefetch_queue: a directed vector table,
// hand-written corner sequences and a randomized run against a byte-queue
// reference model.

module tb_rf80386_prefetch_queue;

  localparam int LB = 16;
  localparam int QB = 32;
  localparam int PK = 8;
  localparam logic [31:0] RST_ADR = 32'hFFF00000;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              flush_i;
  logic [31:0]       flush_adr_i;
  logic              fetch_req_o;
  logic [31:0]       fetch_adr_o;
  logic [LB*8-1:0]   ibundle_i;
  logic              ihit_i;
  logic [PK*8-1:0]   peek_o;
  logic [5:0]        count_o;
  logic [3:0]        take_i;
  logic [31:0]       eip_o;
`ifdef RF80386_PFQ_PERF_EN
  logic [31:0]       hit_cnt_o;
  logic [31:0]       starve_cnt_o;
`endif

  always #5 clk = ~clk;

  rf80386_prefetch_queue #(
    .LINE_BYTES(LB), .QBYTES(QB), .PEEK(PK), .RESET_ADR(RST_ADR)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .flush_adr_i(flush_adr_i),
    .fetch_req_o(fetch_req_o), .fetch_adr_o(fetch_adr_o),
    .ibundle_i(ibundle_i), .ihit_i(ihit_i), .peek_o(peek_o),
    .count_o(count_o), .take_i(take_i), .eip_o(eip_o)
`ifdef RF80386_PFQ_PERF_EN
    , .hit_cnt_o(hit_cnt_o), .starve_cnt_o(starve_cnt_o)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the queue as a plain list of bytes.
  logic [7:0]  mq[$];
  logic [31:0] m_eip;
  logic [31:0] m_fadr;
  bit          m_first;
  bit          m_req;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [LB*8-1:0] line_data(input logic [31:0] adr, input logic [7:0] salt);
    logic [LB*8-1:0] d;
    logic [31:0] a;
    for (int i = 0; i < LB; i++) begin
      a = adr + 32'(i);
      d[i*8 +: 8] = a[7:0] ^ salt;
    end
    return d;
  endfunction

  function automatic logic [63:0] model_peek();
    logic [63:0] p;
    for (int k = 0; k < PK; k++) begin
      p[k*8 +: 8] = (k < mq.size()) ? mq[k] : 8'h90;
    end
    return p;
  endfunction

  task automatic model_step(input bit r, input bit f, input logic [31:0] fa,
                            input bit h, input logic [LB*8-1:0] b, input int t);
    int n;
    int skip;
    logic [31:0] a;
    if (r || f) begin
      a = r ? RST_ADR : fa;
      mq.delete();
      m_eip   = a;
      m_fadr  = {a[31:4], 4'h0};
      m_first = 1'b1;
      m_req   = 1'b0;
    end else begin
      skip = m_first ? int'(m_eip[3:0]) : 0;
      n = (t < mq.size()) ? t : mq.size();
      repeat (n) void'(mq.pop_front());
      m_eip = m_eip + 32'(n);
      if (h && m_req) begin
        for (int i = skip; i < LB; i++) mq.push_back(b[i*8 +: 8]);
        m_fadr  = m_fadr + 32'd16;
        m_first = 1'b0;
      end
      m_req = (QB - mq.size()) >= LB;
    end
  endtask

  task automatic check_model();
    chk("count", 64'(count_o), 64'(mq.size()));
    chk("eip", 64'(eip_o), 64'(m_eip));
    chk("fetch_adr", 64'(fetch_adr_o), 64'(m_fadr));
    chk("fetch_req", 64'(fetch_req_o), 64'(m_req));
    chk("peek", peek_o, model_peek());
  endtask

  // One clock: drive inputs, advance the model at the edge, check at negedge.
  task automatic do_cycle(input bit r, input bit f, input logic [31:0] fa,
                          input bit h, input int t, input logic [7:0] salt);
    logic [LB*8-1:0] b;
    b = line_data(m_fadr, salt);
    rst_i = r; flush_i = f; flush_adr_i = fa; ihit_i = h;
    take_i = 4'(t); ibundle_i = b;
    @(posedge clk);
    model_step(r, f, fa, h, b, t);
    @(negedge clk);
    check_model();
  endtask

  typedef struct {
    bit          rst;
    bit          flush;
    logic [31:0] fadr;
    bit          hit;
    int          take;
    int          e_count;
    logic [31:0] e_eip;
    logic [31:0] e_fadr;
    bit          e_req;
    logic [7:0]  e_peek0;
  } vec_t;

  vec_t tbl[13];

  initial begin
    logic [31:0] sv_hit;
    logic [31:0] sv_starve;
    int r;

    tbl[0]  = '{1'b1, 1'b0, 32'h0,        1'b0, 0, 0,  32'hFFF00000, 32'hFFF00000, 1'b0, 8'h90};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,        1'b1, 0, 0,  32'hFFF00000, 32'hFFF00000, 1'b1, 8'h90};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,        1'b1, 0, 16, 32'hFFF00000, 32'hFFF00010, 1'b1, 8'h00};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,        1'b1, 0, 32, 32'hFFF00000, 32'hFFF00020, 1'b0, 8'h00};
    tbl[4]  = '{1'b0, 1'b0, 32'h0,        1'b1, 0, 32, 32'hFFF00000, 32'hFFF00020, 1'b0, 8'h00};
    tbl[5]  = '{1'b0, 1'b0, 32'h0,        1'b1, 3, 29, 32'hFFF00003, 32'hFFF00020, 1'b0, 8'h03};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,        1'b0, 8, 21, 32'hFFF0000B, 32'hFFF00020, 1'b0, 8'h0B};
    tbl[7]  = '{1'b0, 1'b0, 32'h0,        1'b0, 8, 13, 32'hFFF00013, 32'hFFF00020, 1'b1, 8'h13};
    tbl[8]  = '{1'b0, 1'b0, 32'h0,        1'b1, 0, 29, 32'hFFF00013, 32'hFFF00030, 1'b0, 8'h13};
    tbl[9]  = '{1'b0, 1'b1, 32'h00001005, 1'b1, 5, 0,  32'h00001005, 32'h00001000, 1'b0, 8'h90};
    tbl[10] = '{1'b0, 1'b0, 32'h0,        1'b0, 0, 0,  32'h00001005, 32'h00001000, 1'b1, 8'h90};
    tbl[11] = '{1'b0, 1'b0, 32'h0,        1'b1, 0, 11, 32'h00001005, 32'h00001010, 1'b1, 8'h05};
    tbl[12] = '{1'b0, 1'b0, 32'h0,        1'b0, 2, 9,  32'h00001007, 32'h00001010, 1'b1, 8'h07};

    rst_i = 1'b1; flush_i = 1'b0; flush_adr_i = 32'h0; ihit_i = 1'b0;
    take_i = 4'd0; ibundle_i = '0;
    m_eip = RST_ADR; m_fadr = RST_ADR; m_first = 1'b1; m_req = 1'b0;
    @(negedge clk);

    // Directed vector table.
    for (int i = 0; i < 13; i++) begin
      do_cycle(tbl[i].rst, tbl[i].flush, tbl[i].fadr, tbl[i].hit, tbl[i].take, 8'h00);
      chk($sformatf("tbl%0d_count", i), 64'(count_o), 64'(tbl[i].e_count));
      chk($sformatf("tbl%0d_eip", i), 64'(eip_o), 64'(tbl[i].e_eip));
      chk($sformatf("tbl%0d_fadr", i), 64'(fetch_adr_o), 64'(tbl[i].e_fadr));
      chk($sformatf("tbl%0d_req", i), 64'(fetch_req_o), 64'(tbl[i].e_req));
      chk($sformatf("tbl%0d_peek0", i), 64'(peek_o[7:0]), 64'(tbl[i].e_peek0));
      if (i == 11) chk("flush1005_peek", peek_o, 64'h0C0B0A0908070605);
    end

    // Starvation: two bytes queued, decoder asks for five.
    do_cycle(1'b0, 1'b1, 32'h0000200E, 1'b0, 0, 8'h00);
    do_cycle(1'b0, 1'b0, 32'h0, 1'b0, 0, 8'h00);
`ifdef RF80386_PFQ_PERF_EN
    sv_hit = hit_cnt_o;
`endif
    do_cycle(1'b0, 1'b0, 32'h0, 1'b1, 0, 8'h00);
    chk("starve_count2", 64'(count_o), 64'd2);
`ifdef RF80386_PFQ_PERF_EN
    chk("perf_hit_delta", 64'(hit_cnt_o - sv_hit), 64'd1);
    sv_starve = starve_cnt_o;
`endif
    do_cycle(1'b0, 1'b0, 32'h0, 1'b0, 5, 8'h00);
    chk("starve_count0", 64'(count_o), 64'd0);
    chk("starve_eip", 64'(eip_o), 64'h00002010);
    chk("starve_peek", peek_o, {8{8'h90}});
`ifdef RF80386_PFQ_PERF_EN
    chk("perf_starve_delta", 64'(starve_cnt_o - sv_starve), 64'd1);
`endif

    // Full queue: a hit must be held off while free space is below a line.
    do_cycle(1'b0, 1'b1, 32'h00003000, 1'b0, 0, 8'h00);
    do_cycle(1'b0, 1'b0, 32'h0, 1'b0, 0, 8'h00);
    do_cycle(1'b0, 1'b0, 32'h0, 1'b1, 0, 8'h00);
    do_cycle(1'b0, 1'b0, 32'h0, 1'b1, 0, 8'h00);
    do_cycle(1'b0, 1'b0, 32'h0, 1'b0, 8, 8'h00);
    do_cycle(1'b0, 1'b0, 32'h0, 1'b0, 4, 8'h00);
    chk("full_count20", 64'(count_o), 64'd20);
    do_cycle(1'b0, 1'b0, 32'h0, 1'b1, 3, 8'h00);
    chk("full_count17", 64'(count_o), 64'd17);
    chk("full_req_low", 64'(fetch_req_o), 64'd0);
    chk("full_fadr_held", 64'(fetch_adr_o), 64'h00003020);
    do_cycle(1'b0, 1'b0, 32'h0, 1'b1, 3, 8'h00);
    chk("full_count14", 64'(count_o), 64'd14);
    chk("full_req_back", 64'(fetch_req_o), 64'd1);
    do_cycle(1'b0, 1'b0, 32'h0, 1'b1, 0, 8'h00);
    chk("full_count30", 64'(count_o), 64'd30);
    chk("full_fadr_step", 64'(fetch_adr_o), 64'h00003030);

    // Address wrap across the top of the 32-bit space.
    do_cycle(1'b0, 1'b1, 32'hFFFFFFFC, 1'b0, 0, 8'h00);
    chk("wrap_fadr0", 64'(fetch_adr_o), 64'hFFFFFFF0);
    do_cycle(1'b0, 1'b0, 32'h0, 1'b0, 0, 8'h00);
    do_cycle(1'b0, 1'b0, 32'h0, 1'b1, 0, 8'h00);
    chk("wrap_count4", 64'(count_o), 64'd4);
    chk("wrap_fadr1", 64'(fetch_adr_o), 64'h00000000);
    chk("wrap_peek0", 64'(peek_o[7:0]), 64'hFC);
    do_cycle(1'b0, 1'b0, 32'h0, 1'b1, 0, 8'h00);
    chk("wrap_fadr2", 64'(fetch_adr_o), 64'h00000010);
    do_cycle(1'b0, 1'b0, 32'h0, 1'b0, 4, 8'h00);
    chk("wrap_eip", 64'(eip_o), 64'h00000000);
    chk("wrap_count16", 64'(count_o), 64'd16);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      r = int'($urandom_range(0, 999));
      if (r < 2) begin
        do_cycle(1'b1, 1'b0, 32'h0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 8)), 8'($urandom));
      end else if (r < 25) begin
        do_cycle(1'b0, 1'b1, $urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, 8)), 8'($urandom));
      end else begin
        do_cycle(1'b0, 1'b0, 32'h0, ($urandom_range(0, 9) < 6), int'($urandom_range(0, 8)), 8'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
